kbest_ped_sorter: RTL and testbench
===================================

Name: kbest_ped_sorter

Overview:
- Sequential K-best survivor selector that sits directly downstream of the layer-5/6 expansion stage.
- Accepts that stage's candidate list one candidate per cycle: a partial Euclidean distance (PED) plus its 4-symbol decision tuple (s5..s8).
- Keeps the K smallest PEDs in a parallel-compare insertion register, then streams the survivors out in ascending PED order to the layer-3/4 expansion stage.
- Replaces the full combinational 40-entry sort with a small, timing-friendly structure.

Parameters:
- PED_W, 24, width of the unsigned PED.
- SYM_W, 12, width of one signed symbol value.
- NSYM, 4, number of symbols in a candidate tuple.
- K, 16, number of survivors kept (>=2).
- CNT_W, 8, width of the candidate counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  candidate valid
- in_ready  out  1  sorter accepts candidate
- in_last  in  1  final candidate of the current set
- in_ped  in  PED_W  candidate PED, unsigned
- in_sym  in  NSYM*SYM_W  candidate tuple; symbol i at bits [i*SYM_W +: SYM_W]
- out_valid  out  1  survivor valid
- out_ready  in  1  downstream accepts survivor
- out_last  out  1  final survivor of the set
- out_ped  out  PED_W  survivor PED
- out_sym  out  NSYM*SYM_W  survivor tuple
- out_rank  out  $clog2(K)  survivor position, 0 = smallest
- set_count  out  CNT_W  candidates received in the current set, saturating

Behaviour:
Reset and reset values:
- Reset is asynchronous and active-low on rstn, clocked by clk.
- While rstn=0 and after reset: state=COLLECT, all slot valid bits=0, in_ready=1, out_valid=0, out_last=0, out_ped=0, out_sym=0, out_rank=0, set_count=0.
- Asserting rstn mid-COLLECT or mid-DRAIN discards the set. No partial output follows reset.

State COLLECT:
- in_ready=1, out_valid=0.
- A transfer occurs when in_valid && in_ready.
- Each accepted candidate is compared in the same cycle against all K slots. Empty slots count as +infinity.
- Insertion position p = number of valid slots whose PED <= in_ped. Ties are stable: the earlier arrival stays ahead.
- Slots p..K-2 shift down by one, the candidate is written to slot p, and the old slot K-1 is discarded.
- If p == K, the candidate is dropped.
- set_count increments on every accepted candidate and saturates at 2^CNT_W-1.
- An accepted candidate with in_last=1 moves the state to DRAIN at the next edge.

State DRAIN:
- in_ready=0.
- out_valid=1 starting the cycle after the in_last transfer, so latency is 1 cycle.
- Presents slot r, where r counts from 0. out_rank=r.
- out_* stay stable while out_valid && !out_ready.
- n = min(set_count, K), computed before saturation effects; valid slots are contiguous from 0.
- out_last=1 when r == n-1.
- A transfer with out_last=1 clears all valid bits, set_count and r. The state returns to COLLECT, with in_ready=1 on the next cycle.

Arithmetic:
- PED comparison is unsigned and full width. No rounding or truncation.
- Symbols pass through unmodified.

Boundaries:
- A set of 1 candidate produces 1 output with out_last=1.
- A set with more than K candidates produces exactly K outputs.
- in_valid is ignored during DRAIN; upstream holds the candidate until in_ready.
- A PED equal to the current slot K-1 PED when full is dropped, because of the stable-tie rule.

Test Plan:
- Reverse-order set: 40 candidates, in_ped = 40,39,...,1, in_sym = {id,id,id,id} with id = PED, in_last on the 40th. Required: 16 outputs with PED 1..16, out_rank 0..15, out_last only on PED 16, set_count=40, first out_valid one cycle after the last input.
- Short set: 5 candidates with PED 7,3,9,3,1. Required: outputs 1, 3(first), 3(second), 7, 9. The two 3s keep arrival order (checked via in_sym tags). out_last on 9.
- Single candidate: PED 0x000123 with in_last. Required: one output of 0x000123, rank 0, out_last=1. in_ready returns to 1 the cycle after that transfer.
- Backpressure: during DRAIN of the reverse-order set, hold out_ready=0 for 5 cycles at rank 3. Required: out_ped=4 and out_rank=3 held stable, no skip or duplicate, and in_ready stays 0 throughout.
- Reset mid-drain: pull rstn low after rank 6 has transferred. Required: out_valid=0 immediately (asynchronous). After release, a fresh 3-candidate set with PED 5,2,8 outputs 2,5,8 with no stale entries.
- Saturation and full-width compare: 300 candidates, all 0xFFFFFF except one 0x000000 at arrival 150. Required: set_count=255, the first output is 0x000000 followed by the first 15 arrivals of 0xFFFFFF, 16 outputs total.

Source files
------------

// File: rtl/kbest_ped_sorter.sv
// -----------------------------------------------------------------------------
// kbest_ped_sorter
//
// Sequential K-best survivor selector. Sits between the layer-5/6 expansion
// stage and the layer-3/4 expansion stage.
//
// COLLECT: one candidate (PED + NSYM-symbol tuple) is accepted per cycle.
//   Each candidate is compared in parallel against all K slots. The slots are
//   kept sorted in ascending PED order, and empty slots behave as +infinity.
//   Slots at and below the insertion point shift down by one, and the last
//   slot falls off. Equal PEDs keep arrival order, so a candidate that ties
//   the last survivor of a full register is dropped.
// DRAIN: after the in_last transfer, the valid slots are streamed out in
//   rank order (0 = smallest) with valid/ready handshaking. The transfer of
//   the last survivor clears the set and returns to COLLECT.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   in_valid/in_ready     candidate handshake (in_ready=1 only in COLLECT)
//   in_last               final candidate of the current set
//   in_ped                candidate PED, unsigned
//   in_sym                candidate tuple, symbol i at [i*SYM_W +: SYM_W]
//   out_valid/out_ready   survivor handshake (out_valid=1 only in DRAIN)
//   out_last              final survivor of the set
//   out_ped, out_sym      survivor PED and tuple (zero outside DRAIN)
//   out_rank              survivor position, 0 = smallest
//   set_count             candidates received in the current set, saturating
// -----------------------------------------------------------------------------
module kbest_ped_sorter #(
  parameter int PED_W = 24,
  parameter int SYM_W = 12,
  parameter int NSYM  = 4,
  parameter int K     = 16,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [PED_W-1:0]        in_ped,
  input  logic [NSYM*SYM_W-1:0]   in_sym,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [PED_W-1:0]        out_ped,
  output logic [NSYM*SYM_W-1:0]   out_sym,
  output logic [$clog2(K)-1:0]    out_rank,
  output logic [CNT_W-1:0]        set_count
);

  localparam int RANK_W = $clog2(K);
  localparam int TUP_W  = NSYM * SYM_W;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t                 state;
  logic [RANK_W-1:0]      rank;
  logic [K-1:0]           slot_vld;
  logic [PED_W-1:0]       slot_ped [K];
  logic [TUP_W-1:0]       slot_sym [K];

  logic                   in_fire;
  logic                   out_fire;

  // ---------------------------------------------------------------------------
  // Parallel compare
  //
  // le[i] = slot i is occupied and not larger than the candidate. The register
  // is sorted and filled from slot 0, so le is a thermometer code. Its
  // population count is the insertion position p.
  //   le[i]                 -> slot i stays (i < p)
  //   !le[i] &&  le[i-1]    -> slot i takes the candidate (i == p)
  //   !le[i] && !le[i-1]    -> slot i takes slot i-1 (i > p)
  // Slot 0 sees a virtual le[-1] = 1. If every slot is le, nothing moves and
  // the candidate is dropped (p == K).
  // ---------------------------------------------------------------------------
  logic [K-1:0]           le;
  logic [K-1:0]           prev_le;
  logic [K-1:0]           take_in;
  logic [K-1:0]           take_up;
  logic [PED_W-1:0]       up_ped [K];
  logic [TUP_W-1:0]       up_sym [K];

  for (genvar i = 0; i < K; i++) begin : g_cmp
    // Unsigned, full-width compare. "<=" keeps earlier arrivals ahead on ties.
    assign le[i] = slot_vld[i] && (slot_ped[i] <= in_ped);

    if (i == 0) begin : g_head
      assign prev_le[i] = 1'b1;
      // Slot 0 never shifts from above. Tie it to the candidate so the
      // neighbour array is fully driven.
      assign up_ped[i]  = in_ped;
      assign up_sym[i]  = in_sym;
    end else begin : g_body
      assign prev_le[i] = le[i-1];
      assign up_ped[i]  = slot_ped[i-1];
      assign up_sym[i]  = slot_sym[i-1];
    end
  end

  assign take_in = ~le & prev_le;
  assign take_up = ~le & ~prev_le;

  // ---------------------------------------------------------------------------
  // Handshakes and outputs
  //
  // The outputs are decoded directly from registered state: the state
  // register, the rank counter, and the slot at that rank. They therefore hold
  // steady while out_ready is low.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Valid slots are contiguous from 0. Rank r is therefore the last survivor
  // when slot r+1 is empty or r is the final slot. Shifting the valid vector
  // down by one gives "slot r+1 valid" at index r, and a 0 at index K-1.
  logic [K-1:0] vld_next;
  assign vld_next = slot_vld >> 1;

  assign out_last = out_valid && !vld_next[rank];
  assign out_ped  = out_valid ? slot_ped[rank] : '0;
  assign out_sym  = out_valid ? slot_sym[rank] : '0;
  assign out_rank = rank;

  // ---------------------------------------------------------------------------
  // Slot payload
  // ---------------------------------------------------------------------------
  // NOTE: the PED/tuple storage has no reset. Validity is tracked only by
  // slot_vld, and a slot is always written before it becomes valid. Leaving
  // the wide data flops unreset keeps them off the reset tree.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int i = 0; i < K; i++) begin
        if (take_in[i]) begin
          slot_ped[i] <= in_ped;
          slot_sym[i] <= in_sym;
        end else if (take_up[i]) begin
          slot_ped[i] <= up_ped[i];
          slot_sym[i] <= up_sym[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM: state, slot valid bits, drain rank, candidate counter
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then samples pre-edge values, and ordering between blocks cannot matter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= COLLECT;
      slot_vld  <= '0;
      rank      <= '0;
      set_count <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            // Accepting a candidate either fills the next empty slot or leaves
            // a full register full. The valid vector is a fill-from-0
            // thermometer.
            slot_vld <= {slot_vld[K-2:0], 1'b1};
            if (set_count != {CNT_W{1'b1}}) begin
              set_count <= set_count + CNT_W'(1);
            end
            if (in_last) begin
              state <= DRAIN;
              rank  <= '0;
            end
          end
        end

        DRAIN: begin
          if (out_fire) begin
            if (out_last) begin
              state     <= COLLECT;
              slot_vld  <= '0;
              rank      <= '0;
              set_count <= '0;
            end else begin
              rank <= rank + RANK_W'(1);
            end
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbest_ped_sorter.sv
// -----------------------------------------------------------------------------
// tb_kbest_ped_sorter
//
// Directed, table-driven bench for kbest_ped_sorter. Each set is described by
// a candidate table and an expected-survivor table. Both are filled by hand or
// by simple loops with hand-derived expected orderings, then applied in a
// loop. Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_kbest_ped_sorter;

  localparam int PED_W  = 24;
  localparam int SYM_W  = 12;
  localparam int NSYM   = 4;
  localparam int K      = 16;
  localparam int CNT_W  = 8;
  localparam int RANK_W = $clog2(K);
  localparam int TUP_W  = NSYM * SYM_W;
  localparam int MAXC   = 320;
  localparam int TMO    = 200;

  typedef struct {
    logic [PED_W-1:0] ped;
    logic [TUP_W-1:0] sym;
    logic             last;
  } cand_t;

  typedef struct {
    logic [PED_W-1:0]  ped;
    logic [TUP_W-1:0]  sym;
    logic [RANK_W-1:0] rank;
    logic              last;
  } exp_t;

  logic                clk;
  logic                rstn;
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [PED_W-1:0]    in_ped;
  logic [TUP_W-1:0]    in_sym;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic [PED_W-1:0]    out_ped;
  logic [TUP_W-1:0]    out_sym;
  logic [RANK_W-1:0]   out_rank;
  logic [CNT_W-1:0]    set_count;

  cand_t cand_tab [MAXC];
  exp_t  exp_tab  [K];

  int checks   = 0;
  int failures = 0;

  kbest_ped_sorter #(
    .PED_W(PED_W), .SYM_W(SYM_W), .NSYM(NSYM), .K(K), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_ped    (in_ped),
    .in_sym    (in_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_ped   (out_ped),
    .out_sym   (out_sym),
    .out_rank  (out_rank),
    .set_count (set_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tagged tuple. The symbol values depend on arrival index a, so tied PEDs
  // can be told apart. Some symbol values are negative, to exercise signed
  // pass-through.
  function automatic logic [TUP_W-1:0] make_sym(input int a);
    logic [SYM_W-1:0] t;
    t = SYM_W'(a);
    return {t + 12'd1, 12'hFFF - t, 12'h800 + t, t};
  endfunction

  function automatic logic [TUP_W-1:0] rep_sym(input int id);
    return {NSYM{SYM_W'(id)}};
  endfunction

  task automatic send(input cand_t c, input string tag);
    int t;
    in_valid = 1'b1;
    in_ped   = c.ped;
    in_sym   = c.sym;
    in_last  = c.last;
    t = 0;
    while (!in_ready && t < TMO) begin
      step();
      t++;
    end
    if (t != 0) check({tag, "_in_ready_wait"}, 64'(in_ready), 64'd1);
    step();
  endtask

  task automatic recv(input exp_t e, input string tag);
    int t;
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < TMO) begin
      step();
      t++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_ped"},   64'(out_ped),   64'(e.ped));
    check({tag, "_sym"},   64'(out_sym),   64'(e.sym));
    check({tag, "_rank"},  64'(out_rank),  64'(e.rank));
    check({tag, "_last"},  64'(out_last),  64'(e.last));
    step();
  endtask

  // Applies nc candidates from cand_tab, then drains up to n_drain survivors
  // from exp_tab. If bp_rank >= 0, the output is stalled for 5 cycles at that
  // rank while a bogus candidate is offered on the input. A complete drain
  // also checks the return to COLLECT.
  task automatic run_set(input string name, input int nc, input int ne,
                         input int exp_cnt, input int bp_rank, input int n_drain);
    for (int i = 0; i < nc; i++) send(cand_tab[i], name);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, "_first_valid"}, 64'(out_valid), 64'd1);
    check({name, "_drain_in_ready"}, 64'(in_ready), 64'd0);
    check({name, "_set_count"}, 64'(set_count), 64'(exp_cnt));
    for (int j = 0; j < n_drain; j++) begin
      if (j == bp_rank) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ped    = '0;
        in_sym    = '0;
        in_last   = 1'b1;
        for (int c = 0; c < 5; c++) begin
          step();
          check($sformatf("%s_bp%0d_ped", name, c),  64'(out_ped),  64'(exp_tab[j].ped));
          check($sformatf("%s_bp%0d_rank", name, c), 64'(out_rank), 64'(j));
          check($sformatf("%s_bp%0d_in_ready", name, c), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({name, "_bp_set_count"}, 64'(set_count), 64'(exp_cnt));
      end
      recv(exp_tab[j], $sformatf("%s_out%0d", name, j));
    end
    out_ready = 1'b0;
    if (n_drain == ne) begin
      check({name, "_done_in_ready"},  64'(in_ready),  64'd1);
      check({name, "_done_out_valid"}, 64'(out_valid), 64'd0);
      check({name, "_done_set_count"}, 64'(set_count), 64'd0);
    end
  endtask

  initial begin
    int n;
    rstn      = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_ped    = '0;
    in_sym    = '0;
    out_ready = 1'b0;
    #2 rstn = 1'b0;
    #10;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_ped",   64'(out_ped),   64'd0);
    check("rst_out_sym",   64'(out_sym),   64'd0);
    check("rst_out_rank",  64'(out_rank),  64'd0);
    check("rst_set_count", 64'(set_count), 64'd0);
    step();
    rstn = 1'b1;
    step();
    check("post_rst_in_ready",  64'(in_ready),  64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Reverse-order set: 40..1. Survivors are 1..16. Stall at rank 3.
    for (int i = 0; i < 40; i++) begin
      cand_tab[i] = '{ped: PED_W'(40 - i), sym: rep_sym(40 - i), last: (i == 39)};
    end
    for (int j = 0; j < K; j++) begin
      exp_tab[j] = '{ped: PED_W'(j + 1), sym: rep_sym(j + 1),
                     rank: RANK_W'(j), last: (j == K - 1)};
    end
    run_set("rev", 40, K, 40, 3, K);

    // Short set with a tie: 7,3,9,3,1 -> 1(a4), 3(a1), 3(a3), 7(a0), 9(a2).
    cand_tab[0] = '{ped: 24'd7, sym: make_sym(0), last: 1'b0};
    cand_tab[1] = '{ped: 24'd3, sym: make_sym(1), last: 1'b0};
    cand_tab[2] = '{ped: 24'd9, sym: make_sym(2), last: 1'b0};
    cand_tab[3] = '{ped: 24'd3, sym: make_sym(3), last: 1'b0};
    cand_tab[4] = '{ped: 24'd1, sym: make_sym(4), last: 1'b1};
    exp_tab[0]  = '{ped: 24'd1, sym: make_sym(4), rank: 4'd0, last: 1'b0};
    exp_tab[1]  = '{ped: 24'd3, sym: make_sym(1), rank: 4'd1, last: 1'b0};
    exp_tab[2]  = '{ped: 24'd3, sym: make_sym(3), rank: 4'd2, last: 1'b0};
    exp_tab[3]  = '{ped: 24'd7, sym: make_sym(0), rank: 4'd3, last: 1'b0};
    exp_tab[4]  = '{ped: 24'd9, sym: make_sym(2), rank: 4'd4, last: 1'b1};
    run_set("short", 5, 5, 5, -1, 5);

    // Single candidate.
    cand_tab[0] = '{ped: 24'h000123, sym: make_sym(7), last: 1'b1};
    exp_tab[0]  = '{ped: 24'h000123, sym: make_sym(7), rank: 4'd0, last: 1'b1};
    run_set("single", 1, 1, 1, -1, 1);

    // Reset mid-drain: drain ranks 0..6 of the reverse set, then reset.
    for (int i = 0; i < 40; i++) begin
      cand_tab[i] = '{ped: PED_W'(40 - i), sym: rep_sym(40 - i), last: (i == 39)};
    end
    for (int j = 0; j < K; j++) begin
      exp_tab[j] = '{ped: PED_W'(j + 1), sym: rep_sym(j + 1),
                     rank: RANK_W'(j), last: (j == K - 1)};
    end
    run_set("mid", 40, K, 40, -1, 7);
    check("mid_pre_rst_rank", 64'(out_rank), 64'd7);
    rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    check("mid_rst_set_count", 64'(set_count), 64'd0);
    check("mid_rst_out_rank",  64'(out_rank),  64'd0);
    check("mid_rst_out_last",  64'(out_last),  64'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    check("mid_post_out_valid", 64'(out_valid), 64'd0);
    cand_tab[0] = '{ped: 24'd5, sym: make_sym(0), last: 1'b0};
    cand_tab[1] = '{ped: 24'd2, sym: make_sym(1), last: 1'b0};
    cand_tab[2] = '{ped: 24'd8, sym: make_sym(2), last: 1'b1};
    exp_tab[0]  = '{ped: 24'd2, sym: make_sym(1), rank: 4'd0, last: 1'b0};
    exp_tab[1]  = '{ped: 24'd5, sym: make_sym(0), rank: 4'd1, last: 1'b0};
    exp_tab[2]  = '{ped: 24'd8, sym: make_sym(2), rank: 4'd2, last: 1'b1};
    run_set("fresh", 3, 3, 3, -1, 3);

    // Saturation and full-width compare: 300 x 0xFFFFFF, with 0 at arrival 150.
    // Survivors: 0 (a150), then arrivals 0..14. Later equal PEDs lose the tie.
    for (int i = 0; i < 300; i++) begin
      cand_tab[i] = '{ped: (i == 150) ? 24'h000000 : 24'hFFFFFF,
                      sym: make_sym(i), last: (i == 299)};
    end
    exp_tab[0] = '{ped: 24'h000000, sym: make_sym(150), rank: 4'd0, last: 1'b0};
    for (int j = 1; j < K; j++) begin
      exp_tab[j] = '{ped: 24'hFFFFFF, sym: make_sym(j - 1),
                     rank: RANK_W'(j), last: (j == K - 1)};
    end
    run_set("sat", 300, K, 255, -1, K);

    // Confirm nothing further is emitted after the 16th survivor.
    n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid) n++;
    end
    check("sat_no_extra_outputs", 64'(n), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog, so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
